skin_classifier: RTL and testbench
==================================

SKIN_CLASSIFIER -- requirements
Module: skin_classifier

Interface
REQ-001 Parameter DW, default 8: bit width of each Y/Cb/Cr channel and of each threshold.
REQ-002 Parameter CNT_W, default 20: width of the per-frame skin-pixel counter.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 in_valid / in_ready  in / out  1 / 1  input beat handshake.
REQ-006 in_y, in_cb, in_cr  in  DW each  pixel channels.
REQ-007 in_sof, in_eof  in  1 each  first and last pixel of the frame; qualified by in_valid.
REQ-008 cfg_we  in  1  threshold write strobe.
REQ-009 cfg_addr  in  3  register select: 0 Y_MIN, 1 CB_MIN, 2 CB_MAX, 3 CR_MIN, 4 CR_MAX; addresses 5-7 ignored.
REQ-010 cfg_wdata  in  DW  threshold write data.
REQ-011 out_valid / out_ready  out / in  1 / 1  output beat handshake.
REQ-012 out_skin, out_sof, out_eof  out  1 each  classification result, with the beat's frame markers.
REQ-013 frame_cnt  out  CNT_W  skin-pixel count of the last completed frame (SKIN_FRAME_STATS_EN only).
REQ-014 frame_cnt_valid  out  1  one-cycle strobe marking frame_cnt update (SKIN_FRAME_STATS_EN only).

Function
REQ-015 A beat transfers when valid and ready are both high in the same cycle.
REQ-016 Classification: skin = (Y > Y_MIN) and (CB_MIN < Cb < CB_MAX) and (CR_MIN < Cr < CR_MAX); all comparisons strict and unsigned.
REQ-017 Pipeline has 2 stages: stage 1 registers the comparison results; stage 2 registers the ANDed result and the frame markers.
REQ-018 Latency from input transfer to out_valid is 2 cycles when the pipeline is not stalled.
REQ-019 The pipeline advances when stage 2 is empty or out_ready is high; in_ready equals this advance condition.
REQ-020 Full-throughput streaming: 1 beat per cycle when out_ready is held high.
REQ-021 While stalled, out_* are held stable and no beat is dropped or duplicated.
REQ-022 Thresholds are programmed and active register sets. cfg_we writes the programmed set. The active set loads from the programmed set on each accepted in_sof beat, and that beat uses the newly loaded values.
REQ-023 A cfg write in the same cycle as an accepted in_sof goes to the programmed set only; the active set loads the pre-write values.
REQ-024 Mid-frame cfg writes never change the classification of the current frame.
REQ-025 A beat with both in_sof and in_eof is a valid one-pixel frame.

Reset
REQ-026 While rst_n is low at a clock edge: out_valid, out_skin, out_sof, out_eof, frame_cnt and frame_cnt_valid clear to 0, and both stages become empty.
REQ-027 While rst_n is low at a clock edge, in_ready is 0 in that cycle.
REQ-028 While rst_n is low at a clock edge, the programmed and active thresholds load 80, 125, 180, 190, 225 (for Y_MIN, CB_MIN, CB_MAX, CR_MIN, CR_MAX), masked to DW bits.
REQ-029 Reset mid-frame discards all in-flight beats and the partial frame count; no frame_cnt_valid is produced for that frame.

Configuration
REQ-030 Macro SKIN_FRAME_STATS_EN, when defined: the counter increments on each output transfer with out_skin=1, saturating at 2^CNT_W-1.
REQ-031 With SKIN_FRAME_STATS_EN: an output transfer with out_sof restarts the count (the beat itself counts), discarding any unterminated frame.
REQ-032 With SKIN_FRAME_STATS_EN: on an out_eof transfer, frame_cnt loads the final count (the beat itself counts) one cycle later, and frame_cnt_valid pulses for 1 cycle.
REQ-033 Without SKIN_FRAME_STATS_EN: frame_cnt and frame_cnt_valid are tied to 0 and the counter logic is absent.

Structure
REQ-034 Shared package skin_pkg holds the threshold address constants, the default threshold values, and the DW/CNT_W defaults.
REQ-035 Sub-module skin_frame_stats contains the counter and strobe logic; it is instantiated only under SKIN_FRAME_STATS_EN.

Verification
REQ-036 Reset defaults, out_ready=1: pixel (81,126,191) -> out_skin=1 after 2 cycles; pixels (80,126,191) and (81,180,191) -> out_skin=0.
REQ-037 Stall test: out_ready low for 5 cycles while in_valid is high -> in_ready drops; the 10-beat sequence emerges intact and in order.
REQ-038 Mid-frame write: cfg write Y_MIN=100 mid-frame -> pixel Y=90 stays skin until the next sof; after that sof, Y=90 is not skin.
REQ-039 cfg write in the same cycle as an sof transfer -> the new value applies from the following frame only.
REQ-040 SKIN_FRAME_STATS_EN, 16-pixel frame containing 7 skin pixels -> frame_cnt=7 with a 1-cycle frame_cnt_valid; a one-pixel sof+eof skin frame -> frame_cnt=1.
REQ-041 rst_n low for 1 cycle mid-frame -> outputs clear, thresholds return to defaults, no frame_cnt_valid for the aborted frame.

Source files
------------

// File: rtl/skin_pkg.sv
// -----------------------------------------------------------------------------
// skin_pkg
//
// Purpose:
//   Shared definitions for the YCbCr skin classifier:
//     - default channel width and per-frame counter width
//     - threshold register addresses on the cfg bus
//     - reset values of the five thresholds
//
// No ports. The reset values are plain integers. Each user masks them to its
// own channel width with a width cast.
// -----------------------------------------------------------------------------
package skin_pkg;

    // Default widths
    localparam int DW_DEFAULT    = 8;
    localparam int CNT_W_DEFAULT = 20;

    // Threshold register map (addresses 5..7 are unused and ignored)
    localparam logic [2:0] ADDR_Y_MIN  = 3'd0;
    localparam logic [2:0] ADDR_CB_MIN = 3'd1;
    localparam logic [2:0] ADDR_CB_MAX = 3'd2;
    localparam logic [2:0] ADDR_CR_MIN = 3'd3;
    localparam logic [2:0] ADDR_CR_MAX = 3'd4;

    // Reset values of the thresholds
    localparam int DEF_Y_MIN  = 80;
    localparam int DEF_CB_MIN = 125;
    localparam int DEF_CB_MAX = 180;
    localparam int DEF_CR_MIN = 190;
    localparam int DEF_CR_MAX = 225;

endpackage

// File: rtl/skin_frame_stats.sv
// -----------------------------------------------------------------------------
// skin_frame_stats
//
// Purpose:
//   Counts skin pixels per frame on the output side of the classifier. It
//   publishes the final count of each completed frame together with a
//   one-cycle strobe.
//
// Ports:
//   clk                 in   clock, rising edge
//   rst_n               in   synchronous active-low reset
//   i_xfer              in   an output beat transfers this cycle
//   i_skin              in   classification of that beat
//   i_sof / i_eof       in   frame markers of that beat
//   o_frame_cnt         out  skin count of the last completed frame
//   o_frame_cnt_valid   out  one-cycle strobe, high the cycle after an eof beat
//
// Behaviour:
//   - An sof beat restarts the count and is itself counted. Any unterminated
//     frame is dropped.
//   - The count saturates at all-ones.
//   - An eof beat includes itself in the final count, then clears the running
//     count.
// -----------------------------------------------------------------------------
module skin_frame_stats
    import skin_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_xfer,
    input  logic             i_skin,
    input  logic             i_sof,
    input  logic             i_eof,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic             o_frame_cnt_valid
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_frame_cnt_valid;

    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_next;

    // An sof beat begins from zero rather than from whatever a broken frame
    // left behind.
    always_comb begin
        w_base = i_sof ? '0 : r_cnt;
        w_next = w_base;
        if (i_skin && (w_base != CNT_MAX)) begin
            w_next = w_base + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt             <= '0;
            r_frame_cnt       <= '0;
            r_frame_cnt_valid <= 1'b0;
        end else begin
            r_frame_cnt_valid <= 1'b0;
            if (i_xfer) begin
                if (i_eof) begin
                    r_frame_cnt       <= w_next;
                    r_frame_cnt_valid <= 1'b1;
                    r_cnt             <= '0;
                end else begin
                    r_cnt <= w_next;
                end
            end
        end
    end

    assign o_frame_cnt       = r_frame_cnt;
    assign o_frame_cnt_valid = r_frame_cnt_valid;

endmodule

// File: rtl/skin_classifier.sv
// -----------------------------------------------------------------------------
// skin_classifier
//
// Purpose:
//   Classifies a stream of YCbCr pixels as skin or not skin. A pixel is skin
//   when all of these hold, using strict unsigned compares:
//       Y  > Y_MIN
//       CB_MIN < Cb < CB_MAX
//       CR_MIN < Cr < CR_MAX
//
//   The design is a two-stage pipeline:
//     - Stage 1 registers the five comparison bits.
//     - Stage 2 registers their AND together with the frame markers.
//
// Optional feature (macro SKIN_FRAME_STATS_EN):
//   When defined, skin_frame_stats is instantiated and produces a per-frame
//   skin pixel count. When undefined, frame_cnt and frame_cnt_valid are
//   tied to 0.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         input beat handshake
//   in_y, in_cb, in_cr          pixel channels, DW bits each
//   in_sof, in_eof              first / last pixel of frame (qualified by in_valid)
//   cfg_we, cfg_addr, cfg_wdata threshold write port (programmed set)
//   out_valid / out_ready       output beat handshake
//   out_skin, out_sof, out_eof  result and frame markers of the output beat
//   frame_cnt, frame_cnt_valid  per-frame skin count and its update strobe
//
// Handshake:
//   A beat moves on a port when valid and ready are both high at a rising
//   edge.
//   - A producer holds valid and the data stable until that edge.
//   - The whole pipeline advances together. It advances when stage 2 is
//     empty or out_ready is high.
//   - in_ready is exactly this advance condition, gated low while rst_n is low.
//   - While stalled, every stage holds, so out_* stay stable.
//
// Thresholds:
//   There are two register sets.
//   - cfg_we writes the programmed set.
//   - The active set copies the programmed set on every accepted sof beat.
//   - The sof beat itself is compared against the programmed values. These
//     are the pre-write values when a cfg write lands in the same cycle.
//   - Mid-frame writes therefore cannot alter the frame in flight.
// -----------------------------------------------------------------------------
module skin_classifier
    import skin_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_y,
    input  logic [DW-1:0]    in_cb,
    input  logic [DW-1:0]    in_cr,
    input  logic             in_sof,
    input  logic             in_eof,

    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [DW-1:0]    cfg_wdata,

    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_skin,
    output logic             out_sof,
    output logic             out_eof,

    output logic [CNT_W-1:0] frame_cnt,
    output logic             frame_cnt_valid
);

    // Reset values masked to the channel width
    localparam logic [DW-1:0] RST_Y_MIN  = DW'(DEF_Y_MIN);
    localparam logic [DW-1:0] RST_CB_MIN = DW'(DEF_CB_MIN);
    localparam logic [DW-1:0] RST_CB_MAX = DW'(DEF_CB_MAX);
    localparam logic [DW-1:0] RST_CR_MIN = DW'(DEF_CR_MIN);
    localparam logic [DW-1:0] RST_CR_MAX = DW'(DEF_CR_MAX);

    // -------------------------------------------------------------------------
    // Threshold registers
    // -------------------------------------------------------------------------
    logic [DW-1:0] r_prog_y_min, r_prog_cb_min, r_prog_cb_max;
    logic [DW-1:0] r_prog_cr_min, r_prog_cr_max;
    logic [DW-1:0] r_act_y_min, r_act_cb_min, r_act_cb_max;
    logic [DW-1:0] r_act_cr_min, r_act_cr_max;

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    logic       r_s1_valid;
    logic [4:0] r_s1_cmp;
    logic       r_s1_sof;
    logic       r_s1_eof;

    logic       r_s2_valid;
    logic       r_s2_skin;
    logic       r_s2_sof;
    logic       r_s2_eof;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic          w_advance;
    logic          w_in_xfer;
    logic          w_sof_xfer;
    logic [DW-1:0] w_th_y_min, w_th_cb_min, w_th_cb_max;
    logic [DW-1:0] w_th_cr_min, w_th_cr_max;
    logic [4:0]    w_cmp;

    assign w_advance  = ~r_s2_valid | out_ready;
    assign in_ready   = w_advance & rst_n;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_sof_xfer = w_in_xfer & in_sof;

    // The sof beat sees the values that the active set is about to load.
    assign w_th_y_min  = w_sof_xfer ? r_prog_y_min  : r_act_y_min;
    assign w_th_cb_min = w_sof_xfer ? r_prog_cb_min : r_act_cb_min;
    assign w_th_cb_max = w_sof_xfer ? r_prog_cb_max : r_act_cb_max;
    assign w_th_cr_min = w_sof_xfer ? r_prog_cr_min : r_act_cr_min;
    assign w_th_cr_max = w_sof_xfer ? r_prog_cr_max : r_act_cr_max;

    assign w_cmp[4] = in_y  > w_th_y_min;
    assign w_cmp[3] = in_cb > w_th_cb_min;
    assign w_cmp[2] = in_cb < w_th_cb_max;
    assign w_cmp[1] = in_cr > w_th_cr_min;
    assign w_cmp[0] = in_cr < w_th_cr_max;

    // -------------------------------------------------------------------------
    // Programmed set: written by cfg. Active set: loaded on an accepted sof.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prog_y_min  <= RST_Y_MIN;
            r_prog_cb_min <= RST_CB_MIN;
            r_prog_cb_max <= RST_CB_MAX;
            r_prog_cr_min <= RST_CR_MIN;
            r_prog_cr_max <= RST_CR_MAX;
            r_act_y_min   <= RST_Y_MIN;
            r_act_cb_min  <= RST_CB_MIN;
            r_act_cb_max  <= RST_CB_MAX;
            r_act_cr_min  <= RST_CR_MIN;
            r_act_cr_max  <= RST_CR_MAX;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_Y_MIN:  r_prog_y_min  <= cfg_wdata;
                    ADDR_CB_MIN: r_prog_cb_min <= cfg_wdata;
                    ADDR_CB_MAX: r_prog_cb_max <= cfg_wdata;
                    ADDR_CR_MIN: r_prog_cr_min <= cfg_wdata;
                    ADDR_CR_MAX: r_prog_cr_max <= cfg_wdata;
                    default:     ;
                endcase
            end
            // Loads the pre-write programmed values, because the cfg write
            // above only takes effect after this edge.
            if (w_sof_xfer) begin
                r_act_y_min  <= r_prog_y_min;
                r_act_cb_min <= r_prog_cb_min;
                r_act_cb_max <= r_prog_cb_max;
                r_act_cr_min <= r_prog_cr_min;
                r_act_cr_max <= r_prog_cr_max;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: comparison bits and markers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_cmp   <= '0;
            r_s1_sof   <= 1'b0;
            r_s1_eof   <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_cmp   <= w_cmp;
            r_s1_sof   <= in_valid & in_sof;
            r_s1_eof   <= in_valid & in_eof;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: final result and markers, driven straight to the outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_skin  <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_eof   <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_skin  <= r_s1_valid & (&r_s1_cmp);
            r_s2_sof   <= r_s1_sof;
            r_s2_eof   <= r_s1_eof;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_skin  = r_s2_skin;
    assign out_sof   = r_s2_sof;
    assign out_eof   = r_s2_eof;

    // -------------------------------------------------------------------------
    // Per-frame statistics
    // -------------------------------------------------------------------------
`ifdef SKIN_FRAME_STATS_EN
    skin_frame_stats #(
        .CNT_W (CNT_W)
    ) u_frame_stats (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_xfer            (r_s2_valid & out_ready),
        .i_skin            (r_s2_skin),
        .i_sof             (r_s2_sof),
        .i_eof             (r_s2_eof),
        .o_frame_cnt       (frame_cnt),
        .o_frame_cnt_valid (frame_cnt_valid)
    );
`else
    assign frame_cnt       = '0;
    assign frame_cnt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_skin_classifier.sv
// -----------------------------------------------------------------------------
// tb_skin_classifier
//
// Directed bench for skin_classifier.
//   - Inputs are driven 1 time unit after the rising edge.
//   - Outputs are sampled on the falling edge.
//   - Expected beats {skin, sof, eof} are pushed when a beat is accepted, and
//     popped in order as output beats transfer.
// Frame-count checks apply when SKIN_FRAME_STATS_EN is defined. Otherwise the
// bench checks that both stats outputs stay at 0.
// -----------------------------------------------------------------------------
module tb_skin_classifier;
    import skin_pkg::*;

    localparam int DW    = 8;
    localparam int CNT_W = 20;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_y, in_cb, in_cr;
    logic             in_sof, in_eof;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [DW-1:0]    cfg_wdata;
    logic             out_valid;
    logic             out_ready;
    logic             out_skin, out_sof, out_eof;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_cnt_valid;

    skin_classifier #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_y            (in_y),
        .in_cb           (in_cb),
        .in_cr           (in_cr),
        .in_sof          (in_sof),
        .in_eof          (in_eof),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_skin        (out_skin),
        .out_sof         (out_sof),
        .out_eof         (out_eof),
        .frame_cnt       (frame_cnt),
        .frame_cnt_valid (frame_cnt_valid)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- scoreboard
    int              checks;
    int              failures;
    logic [2:0]      exp_q[$];
    int              fcv_pulses;
    logic [CNT_W-1:0] last_fc;
    logic            exp_fcv_next;
    logic            prev_stall;
    logic [2:0]      prev_out;
    logic            saw_backpressure;

    typedef struct {
        logic [DW-1:0] y;
        logic [DW-1:0] cb;
        logic [DW-1:0] cr;
        logic          skin;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic monitor_step();
        logic [2:0] e;
        if (!rst_n) begin
            exp_fcv_next = 1'b0;
            prev_stall   = 1'b0;
            return;
        end
        check("frame_cnt_valid_timing", {31'd0, frame_cnt_valid}, {31'd0, exp_fcv_next});
        if (frame_cnt_valid) begin
            fcv_pulses++;
            last_fc = frame_cnt;
        end
        if (prev_stall) begin
            check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            check("stall_hold_data", {29'd0, out_skin, out_sof, out_eof}, {29'd0, prev_out});
        end
        if (in_valid && !in_ready) saw_backpressure = 1'b1;
        exp_fcv_next = 1'b0;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0b required=none", {out_skin, out_sof, out_eof});
            end else begin
                e = exp_q.pop_front();
                check("out_beat_skin_sof_eof", {29'd0, out_skin, out_sof, out_eof}, {29'd0, e});
            end
`ifdef SKIN_FRAME_STATS_EN
            exp_fcv_next = out_eof;
`endif
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_skin, out_sof, out_eof};
    endtask

    // --------------------------------------------------------- driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] y, input logic [DW-1:0] cb,
                             input logic [DW-1:0] cr, input logic sof,
                             input logic eof, input logic skin);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_y     = y;
        in_cb    = cb;
        in_cr    = cr;
        in_sof   = sof;
        in_eof   = eof;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({skin, sof, eof});
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [DW-1:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check(name, exp_q.size(), 32'd0);
        tick(2);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        idle();
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_markers", {29'd0, out_skin, out_sof, out_eof}, 32'd0);
        check("reset_frame_cnt", frame_cnt, 32'd0);
        check("reset_frame_cnt_valid", {31'd0, frame_cnt_valid}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic check_count(input string name, input int required);
`ifdef SKIN_FRAME_STATS_EN
        check(name, last_fc, required);
`else
        check(name, frame_cnt, 32'd0);
`endif
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        int            pc;
        logic [15:0]   mask;
        checks = 0; failures = 0; fcv_pulses = 0; last_fc = '0;
        exp_fcv_next = 1'b0; prev_stall = 1'b0; prev_out = '0; saw_backpressure = 1'b0;
        rst_n = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_y = '0; in_cb = '0; in_cr = '0; in_sof = 1'b0; in_eof = 1'b0;

        vecs[0]  = '{8'd81,  8'd126, 8'd191, 1'b1};
        vecs[1]  = '{8'd80,  8'd126, 8'd191, 1'b0};
        vecs[2]  = '{8'd81,  8'd180, 8'd191, 1'b0};
        vecs[3]  = '{8'd81,  8'd125, 8'd191, 1'b0};
        vecs[4]  = '{8'd81,  8'd179, 8'd224, 1'b1};
        vecs[5]  = '{8'd81,  8'd126, 8'd190, 1'b0};
        vecs[6]  = '{8'd81,  8'd126, 8'd225, 1'b0};
        vecs[7]  = '{8'd255, 8'd150, 8'd200, 1'b1};
        vecs[8]  = '{8'd0,   8'd150, 8'd200, 1'b0};
        vecs[9]  = '{8'd200, 8'd124, 8'd200, 1'b0};
        vecs[10] = '{8'd200, 8'd181, 8'd200, 1'b0};
        vecs[11] = '{8'd200, 8'd150, 8'd226, 1'b0};

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        tick(3);
        do_reset();

        // Latency: a one-pixel skin frame appears 2 cycles after acceptance.
        send_beat(8'd81, 8'd126, 8'd191, 1'b1, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        check("latency_cycle1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_cycle2_valid", {31'd0, out_valid}, 32'd1);
        check("latency_cycle2_skin", {31'd0, out_skin}, 32'd1);
        tick(1);
        wait_drain("drain_latency");
        check_count("one_pixel_frame_cnt", 1);

        // Table of boundary vectors in one frame, default thresholds.
        for (int i = 0; i < 12; i++) begin
            send_beat(vecs[i].y, vecs[i].cb, vecs[i].cr, i == 0, i == 11, vecs[i].skin);
        end
        idle();
        wait_drain("drain_table");
        check_count("table_frame_cnt", 3);

        // Stall: out_ready low for 5 cycles while a 10-beat frame streams in.
        saw_backpressure = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send_beat((i % 3 == 1) ? 8'd70 : 8'(100 + i), 8'd150, 8'd200,
                              i == 0, i == 9, i % 3 != 1);
                end
                idle();
            end
            begin
                tick(3);
                out_ready = 1'b0;
                tick(5);
                out_ready = 1'b1;
            end
        join
        wait_drain("drain_stall");
        check("stall_in_ready_dropped", {31'd0, saw_backpressure}, 32'd1);
        check_count("stall_frame_cnt", 7);

        // Mid-frame write of Y_MIN=100 only takes effect at the next sof.
        send_beat(8'd90, 8'd150, 8'd200, 1'b1, 1'b0, 1'b1);
        send_beat(8'd90, 8'd150, 8'd200, 1'b0, 1'b0, 1'b1);
        idle();
        cfg_write(ADDR_Y_MIN, 8'd100);
        send_beat(8'd90, 8'd150, 8'd200, 1'b0, 1'b0, 1'b1);
        send_beat(8'd90, 8'd150, 8'd200, 1'b0, 1'b1, 1'b1);
        send_beat(8'd90, 8'd150, 8'd200, 1'b1, 1'b0, 1'b0);
        send_beat(8'd150, 8'd150, 8'd200, 1'b0, 1'b1, 1'b1);
        idle();
        wait_drain("drain_midframe");

        // Write Y_MIN=60 in the same cycle as an sof: the old value 100 stays for this frame.
        cfg_we    = 1'b1;
        cfg_addr  = ADDR_Y_MIN;
        cfg_wdata = 8'd60;
        send_beat(8'd90, 8'd150, 8'd200, 1'b1, 1'b0, 1'b0);
        cfg_we    = 1'b0;
        send_beat(8'd70, 8'd150, 8'd200, 1'b0, 1'b0, 1'b0);
        send_beat(8'd70, 8'd150, 8'd200, 1'b0, 1'b1, 1'b0);
        send_beat(8'd70, 8'd150, 8'd200, 1'b1, 1'b0, 1'b1);
        send_beat(8'd60, 8'd150, 8'd200, 1'b0, 1'b0, 1'b0);
        send_beat(8'd61, 8'd150, 8'd200, 1'b0, 1'b1, 1'b1);
        idle();
        wait_drain("drain_same_cycle_cfg");

        // 16-pixel frame with skin at pixels 0,2,3,7,9,12,15.
        mask = 16'h928D;
        pc   = fcv_pulses;
        for (int i = 0; i < 16; i++) begin
            send_beat(8'd100, 8'd150, mask[i] ? 8'd200 : 8'd230, i == 0, i == 15, mask[i]);
        end
        idle();
        wait_drain("drain_stats16");
        check_count("stats16_frame_cnt", 7);
`ifdef SKIN_FRAME_STATS_EN
        check("stats16_one_pulse", fcv_pulses, pc + 1);
`else
        check("stats_disabled_no_pulse", fcv_pulses, 32'd0);
`endif

        // An unterminated frame is dropped when a new sof arrives.
        send_beat(8'd100, 8'd150, 8'd200, 1'b1, 1'b0, 1'b1);
        send_beat(8'd100, 8'd150, 8'd200, 1'b0, 1'b0, 1'b1);
        send_beat(8'd100, 8'd150, 8'd200, 1'b1, 1'b1, 1'b1);
        idle();
        wait_drain("drain_restart");
        check_count("restart_frame_cnt", 1);

        // Reset mid-frame: beats discarded, no strobe, thresholds back to defaults.
        send_beat(8'd100, 8'd150, 8'd200, 1'b1, 1'b0, 1'b1);
        send_beat(8'd100, 8'd150, 8'd200, 1'b0, 1'b0, 1'b1);
        send_beat(8'd100, 8'd150, 8'd200, 1'b0, 1'b0, 1'b1);
        pc = fcv_pulses;
        do_reset();
        tick(4);
        check("reset_abort_no_pulse", fcv_pulses, pc);
        check("reset_abort_out_valid", {31'd0, out_valid}, 32'd0);
        send_beat(8'd70, 8'd150, 8'd200, 1'b1, 1'b0, 1'b0);
        send_beat(8'd81, 8'd150, 8'd200, 1'b0, 1'b1, 1'b1);
        idle();
        wait_drain("drain_post_reset");
        check_count("post_reset_frame_cnt", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
